weight_monitor: RTL

- Clocked, parametrised load monitor for the elevator car. It replaces pulse-clocked weight counting.
- Synchronises asynchronous passenger-in/out weight pulses and keeps a saturating up/down load count while the door is open.
- Drives an overload flag with hysteresis, a near-limit warning and a door-hold request to the door controller.
- Sits between the weight sensor front-end and the car/door control FSM.

---
 rtl/elevator_pkg.sv | 15 +
 rtl/weight_monitor_if.sv | 29 ++
 rtl/sync_edge.sv | 44 ++++
 rtl/weight_monitor.sv | 132 +++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions used by the weight monitor and the door controller.
// Holds the load-monitor state encoding and the default load limits.
package elevator_pkg;

  typedef logic [1:0] wm_state_t;

  localparam wm_state_t ST_NORMAL = 2'd0;
  localparam wm_state_t ST_WARN   = 2'd1;
  localparam wm_state_t ST_OVER   = 2'd2;

  localparam int unsigned DEFAULT_COUNT_W = 8;
  localparam int unsigned DEFAULT_LIMIT   = 10;
  localparam int unsigned DEFAULT_HYST    = 2;

endpackage

// File: rtl/weight_monitor_if.sv
// Signal bundle between the weight sensor front-end / car controller and the
// load monitor.
//   master: drives clear, door_open, weight_inc, weight_dec; reads status
//   slave : the monitor; reads the controls, drives load_count and flags
interface weight_monitor_if
  import elevator_pkg::*;
#(
  parameter int unsigned COUNT_W = DEFAULT_COUNT_W
);
  logic               clear;
  logic               door_open;
  logic               weight_inc;
  logic               weight_dec;
  logic [COUNT_W-1:0] load_count;
  logic               weight_limit_exceeded;
  logic               near_limit;
  logic               door_hold;
  logic               underflow_err;

  modport master (
    output clear, door_open, weight_inc, weight_dec,
    input  load_count, weight_limit_exceeded, near_limit, door_hold, underflow_err
  );

  modport slave (
    input  clear, door_open, weight_inc, weight_dec,
    output load_count, weight_limit_exceeded, near_limit, door_hold, underflow_err
  );
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
//   clk, weight_flip_reset : clock and async active-high reset
//   clear                  : synchronous clear, same effect as reset
//   din                    : asynchronous input level
//   pulse                  : one-cycle pulse per rising edge of din
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic weight_flip_reset,
  input  logic clear,
  input  logic din,
  output logic pulse
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;
  logic              hist_q;
  logic              armed_q;

  // fill_q/armed_q keep the detector quiet until the history flop holds a
  // real post-reset sample, so an input held high across reset is not
  // mistaken for a new edge.
  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse   <= 1'b0;
    end else if (clear) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], din};
      fill_q  <= {fill_q[STAGES-2:0], 1'b1};
      hist_q  <= sync_q[STAGES-1];
      armed_q <= fill_q[STAGES-1];
      pulse   <= sync_q[STAGES-1] & ~hist_q & armed_q;
    end
  end
endmodule

// File: rtl/weight_monitor.sv
// Elevator car load monitor: saturating up/down load count while the door is
// open, overload flag with hysteresis, near-limit warning, door-hold request.
//   clk, weight_flip_reset : clock and async active-high reset
//   bus (slave)            : clear/door_open/weight_inc/weight_dec in,
//                            load_count and status flags out (all registered)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_NORMAL | load below warning threshold
// ST_WARN   | load at or above LIMIT-WARN_MARGIN, not overloaded
// ST_OVER   | overloaded; held until load <= LIMIT-HYST
module weight_monitor
  import elevator_pkg::*;
#(
  parameter int unsigned COUNT_W     = DEFAULT_COUNT_W,
  parameter int unsigned LIMIT       = DEFAULT_LIMIT,
  parameter int unsigned HYST        = DEFAULT_HYST,
  parameter int unsigned WARN_MARGIN = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            weight_flip_reset,
  weight_monitor_if.slave bus
);
  if (LIMIT + 1 > (2 ** COUNT_W) - 1) begin : g_chk_width
    $error("weight_monitor: LIMIT+1 does not fit in COUNT_W bits");
  end
  if (HYST == 0 || HYST > LIMIT) begin : g_chk_hyst
    $error("weight_monitor: HYST must be in 1..LIMIT");
  end
  if (WARN_MARGIN >= LIMIT) begin : g_chk_warn
    $error("weight_monitor: WARN_MARGIN must be below LIMIT");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("weight_monitor: SYNC_STAGES must be at least 2");
  end

  localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(LIMIT + 1);
  localparam logic [COUNT_W-1:0] LIM     = COUNT_W'(LIMIT);
  localparam logic [COUNT_W-1:0] WARN_TH = COUNT_W'(LIMIT - WARN_MARGIN);
  localparam logic [COUNT_W-1:0] CLR_TH  = COUNT_W'(LIMIT - HYST);

  logic [SYNC_STAGES-1:0] door_sync_q;
  logic                   door_s;
  logic                   inc_p;
  logic                   dec_p;

  logic [COUNT_W-1:0] count_q, count_nx;
  wm_state_t          state_q, state_nx;
  logic               uflow_q, uflow_nx;
  logic               over_q;
  logic               near_q;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_inc (
    .clk               (clk),
    .weight_flip_reset (weight_flip_reset),
    .clear             (bus.clear),
    .din               (bus.weight_inc),
    .pulse             (inc_p)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dec (
    .clk               (clk),
    .weight_flip_reset (weight_flip_reset),
    .clear             (bus.clear),
    .din               (bus.weight_dec),
    .pulse             (dec_p)
  );

  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      door_sync_q <= '0;
    end else if (bus.clear) begin
      door_sync_q <= '0;
    end else begin
      door_sync_q <= {door_sync_q[SYNC_STAGES-2:0], bus.door_open};
    end
  end

  assign door_s = door_sync_q[SYNC_STAGES-1];

  always_comb begin
    count_nx = count_q;
    uflow_nx = uflow_q;
    if (door_s && inc_p && !dec_p) begin
      if (count_q != CNT_MAX) count_nx = count_q + COUNT_W'(1);
    end else if (door_s && dec_p && !inc_p) begin
      if (count_q == '0) uflow_nx = 1'b1;
      else               count_nx = count_q - COUNT_W'(1);
    end

    state_nx = state_q;
    case (state_q)
      ST_OVER: begin
        if (count_nx <= CLR_TH) state_nx = (count_nx >= WARN_TH) ? ST_WARN : ST_NORMAL;
      end
      default: begin
        if (count_nx > LIM)           state_nx = ST_OVER;
        else if (count_nx >= WARN_TH) state_nx = ST_WARN;
        else                          state_nx = ST_NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      count_q <= '0;
      state_q <= ST_NORMAL;
      uflow_q <= 1'b0;
      over_q  <= 1'b0;
      near_q  <= 1'b0;
    end else if (bus.clear) begin
      count_q <= '0;
      state_q <= ST_NORMAL;
      uflow_q <= 1'b0;
      over_q  <= 1'b0;
      near_q  <= 1'b0;
    end else begin
      count_q <= count_nx;
      state_q <= state_nx;
      uflow_q <= uflow_nx;
      over_q  <= (state_nx == ST_OVER);
      near_q  <= (state_nx == ST_WARN);
    end
  end

  assign bus.load_count            = count_q;
  assign bus.weight_limit_exceeded = over_q;
  assign bus.door_hold             = over_q;
  assign bus.near_limit            = near_q;
  assign bus.underflow_err         = uflow_q;
endmodule
